// File: rtl/vga_stream_pkg.sv
// Shared constants and types for the VGA Avalon-ST pixel sink.
// Frame geometry, capture window, pixel field positions and sink states.
package vga_stream_pkg;
    localparam int ROW_PIXELS    = 640;
    localparam int FRAME_ROWS    = 480;
    localparam int FRAME_PIXELS  = ROW_PIXELS * FRAME_ROWS;
    localparam int CAPTURE_START = 80;
    localparam int CAPTURE_END   = 560;

    // Top bit of each 10-bit colour channel in {R,G,B}
    localparam int R_MSB = 29;
    localparam int G_MSB = 19;
    localparam int B_MSB = 9;

    typedef enum logic [1:0] {
        HUNT,
        RECV,
        WAIT_BANK
    } sink_state_t;
endpackage

// File: rtl/vga_row_bank_tracker.sv
// Two-entry held-bank FIFO for the row buffer: banks fill alternately and
// are freed oldest-first, so a count plus the write bank is sufficient.
module vga_row_bank_tracker (
    input  logic clk,
    input  logic rst_n,
    input  logic mark,
    input  logic free,
    output logic wr_bank,
    output logic full
);
    logic [1:0] held;
    logic [1:0] after_free;
    logic [1:0] held_next;
    logic       freed;

    // A release in the same cycle as a completion is applied first
    always_comb begin
        freed      = free && (held != 2'd0);
        after_free = held - {1'b0, freed};
        held_next  = after_free + {1'b0, mark};
        full       = (held_next == 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held    <= 2'd0;
            wr_bank <= 1'b0;
        end else begin
            held <= held_next;
            if (mark) begin
                wr_bank <= !wr_bank;
            end
        end
    end
endmodule

// File: rtl/vga_stream_sink.sv
// Avalon-ST sink for the 30-bit VGA pixel stream: recovers row/column and
// captures a centred window of each row into a double-banked row buffer.
module vga_stream_sink #(
    parameter int ROW_PIXELS    = vga_stream_pkg::ROW_PIXELS,
    parameter int FRAME_ROWS    = vga_stream_pkg::FRAME_ROWS,
    parameter int CAPTURE_START = vga_stream_pkg::CAPTURE_START,
    parameter int CAPTURE_END   = vga_stream_pkg::CAPTURE_END
) (
    input  logic        clock_vga,
    input  logic        reset_vga_n,
    input  logic [29:0] avalon_streaming_sink_data,
    input  logic        avalon_streaming_sink_startofpacket,
    input  logic        avalon_streaming_sink_endofpacket,
    input  logic        avalon_streaming_sink_valid,
    output logic        avalon_streaming_sink_ready,
    output logic        buf_write,
    output logic [9:0]  buf_address,
    output logic [23:0] buf_data,
    output logic        row_ready,
    output logic        row_bank,
    output logic [8:0]  row_index,
    input  logic        row_release,
    output logic        frame_done,
    output logic [7:0]  error_count
);
    import vga_stream_pkg::*;

    localparam logic [9:0] LAST_COL  = 10'(ROW_PIXELS - 1);
    localparam logic [8:0] LAST_ROW  = 9'(FRAME_ROWS - 1);
    localparam logic [9:0] WIN_START = 10'(CAPTURE_START);
    localparam logic [9:0] WIN_END   = 10'(CAPTURE_END);

    sink_state_t state;
    sink_state_t resume;
    logic [9:0]  col;
    logic [8:0]  row;
    logic [9:0]  pc;
    logic [8:0]  pr;
    logic [9:0]  win_col;
    logic        sop;
    logic        eop;
    logic        accept;
    logic        in_recv;
    logic        at_origin;
    logic        at_last;
    logic        pix;
    logic        complete;
    logic        last_px;
    logic        in_window;
    logic        any_err;
    logic        to_hunt;
    logic        wr_bank;
    logic        bank_full;
    logic        unused_bits;

    assign sop = avalon_streaming_sink_startofpacket;
    assign eop = avalon_streaming_sink_endofpacket;
    assign avalon_streaming_sink_ready = reset_vga_n && (state != WAIT_BANK);
    assign accept = avalon_streaming_sink_valid && avalon_streaming_sink_ready;
    assign unused_bits = ^{avalon_streaming_sink_data[R_MSB-8 -: 2],
                           avalon_streaming_sink_data[G_MSB-8 -: 2],
                           avalon_streaming_sink_data[B_MSB-8 -: 2]};

    // An SOP beat is always pixel (0,0), whatever position it arrives at
    always_comb begin
        in_recv   = accept && (state == RECV);
        at_origin = (col == '0) && (row == '0);
        at_last   = (col == LAST_COL) && (row == LAST_ROW);
        pix       = accept && (sop || (state == RECV && !at_origin
                                       && !(eop && !at_last)));
        pc        = sop ? '0 : col;
        pr        = sop ? '0 : row;
        complete  = pix && (pc == LAST_COL);
        last_px   = complete && (pr == LAST_ROW);
        to_hunt   = (in_recv && !sop && at_origin)
                  || (in_recv && !sop && !at_origin && eop && !at_last)
                  || (last_px && !eop);
        any_err   = to_hunt || (in_recv && sop && !at_origin);
        win_col   = pc - WIN_START;
        in_window = (pc >= WIN_START) && (pc < WIN_END);
    end

    vga_row_bank_tracker u_banks (
        .clk     (clock_vga),
        .rst_n   (reset_vga_n),
        .mark    (complete),
        .free    (row_release),
        .wr_bank (wr_bank),
        .full    (bank_full)
    );

    always_ff @(posedge clock_vga or negedge reset_vga_n) begin
        if (!reset_vga_n) begin
            state       <= HUNT;
            resume      <= HUNT;
            col         <= '0;
            row         <= '0;
            buf_write   <= 1'b0;
            buf_address <= '0;
            buf_data    <= '0;
            row_ready   <= 1'b0;
            row_bank    <= 1'b0;
            row_index   <= '0;
            frame_done  <= 1'b0;
            error_count <= '0;
        end else begin
            buf_write  <= pix && in_window;
            row_ready  <= complete;
            frame_done <= last_px && eop;
            if (pix && in_window) begin
                buf_address <= {wr_bank, win_col[8:0]};
                buf_data    <= {avalon_streaming_sink_data[R_MSB -: 8],
                                avalon_streaming_sink_data[G_MSB -: 8],
                                avalon_streaming_sink_data[B_MSB -: 8]};
            end
            if (complete) begin
                row_bank  <= wr_bank;
                row_index <= pr;
            end
            if (any_err && error_count != 8'hFF) begin
                error_count <= error_count + 8'd1;
            end
            if (complete) begin
                col <= '0;
                row <= last_px ? '0 : pr + 9'd1;
            end else if (pix) begin
                col <= pc + 10'd1;
                row <= pr;
            end else if (to_hunt) begin
                col <= '0;
                row <= '0;
            end
            if (complete && bank_full) begin
                state  <= WAIT_BANK;
                resume <= to_hunt ? HUNT : RECV;
            end else if (state == WAIT_BANK) begin
                if (row_release) begin
                    state <= resume;
                end
            end else if (to_hunt) begin
                state <= HUNT;
            end else if (pix) begin
                state <= RECV;
            end
        end
    end
endmodule

// File: tb/tb_vga_stream_sink.sv
// Bench for vga_stream_sink: vector table, directed corner sequences and
// random traffic checked against a linear-position frame model.
module tb_vga_stream_sink;
    localparam int COLS  = 640;
    localparam int ROWS  = 12;
    localparam int FRAME = COLS * ROWS;
    localparam int CS    = 80;
    localparam int CE    = 560;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] sink_data;
    logic        sop;
    logic        eop;
    logic        valid;
    logic        ready;
    logic        buf_write;
    logic [9:0]  buf_address;
    logic [23:0] buf_data;
    logic        row_ready;
    logic        row_bank;
    logic [8:0]  row_index;
    logic        row_release;
    logic        frame_done;
    logic [7:0]  error_count;

    always #5 clk = ~clk;

    vga_stream_sink #(.FRAME_ROWS(ROWS)) dut (
        .clock_vga                           (clk),
        .reset_vga_n                         (rst_n),
        .avalon_streaming_sink_data          (sink_data),
        .avalon_streaming_sink_startofpacket (sop),
        .avalon_streaming_sink_endofpacket   (eop),
        .avalon_streaming_sink_valid         (valid),
        .avalon_streaming_sink_ready         (ready),
        .buf_write                           (buf_write),
        .buf_address                         (buf_address),
        .buf_data                            (buf_data),
        .row_ready                           (row_ready),
        .row_bank                            (row_bank),
        .row_index                           (row_index),
        .row_release                         (row_release),
        .frame_done                          (frame_done),
        .error_count                         (error_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: position is a linear pixel index within the frame
    logic m_hunt;
    logic m_wait;
    int   m_pos;
    int   m_held[$];
    int   m_wbank;
    int   m_err;
    logic e_wr;
    logic e_rr;
    logic e_fd;
    int   e_addr;
    int   e_data;
    int   e_bank;
    int   e_idx;

    int   gpos;
    int   cyc = 0;
    int   rel_due[$];
    logic last_acc;
    logic obs_ready;
    logic rdy_low;
    int   n_rr;
    int   n_wr;
    int   n_fd;
    int   first_idx;
    int   wr_min;
    int   wr_max;

    typedef struct {
        logic v;
        logic s;
        logic e;
        logic rdy;
        logic wr;
        int   err;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_hunt  = 1'b1;
        m_wait  = 1'b0;
        m_pos   = 0;
        m_held.delete();
        m_wbank = 0;
        m_err   = 0;
        gpos    = 0;
        rel_due.delete();
    endtask

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_pixel(input int p, input logic [29:0] d,
                               input logic e);
        int c;
        int r;
        logic [31:0] dw;
        c  = p % COLS;
        r  = p / COLS;
        dw = {2'b00, d};
        if (c >= CS && c < CE) begin
            e_wr   = 1'b1;
            e_addr = m_wbank * 512 + (c - CS);
            e_data = (((dw >> 22) & 255) << 16) | (((dw >> 12) & 255) << 8)
                   | ((dw >> 2) & 255);
        end
        m_pos = p + 1;
        if (c == COLS - 1) begin
            e_rr   = 1'b1;
            e_bank = m_wbank;
            e_idx  = r;
            m_held.push_back(m_wbank);
            m_wbank ^= 1;
            if (m_held.size() == 2) m_wait = 1'b1;
            if (p == FRAME - 1) begin
                m_pos = 0;
                if (e) e_fd = 1'b1;
                else begin
                    bump_err();
                    m_hunt = 1'b1;
                end
            end
        end
    endtask

    task automatic model_beat(input logic [29:0] d, input logic s,
                              input logic e);
        if (m_hunt) begin
            if (s) begin
                m_hunt = 1'b0;
                model_pixel(0, d, e);
            end
        end else if (s) begin
            if (m_pos != 0) bump_err();
            model_pixel(0, d, e);
        end else if (m_pos == 0) begin
            bump_err();
            m_hunt = 1'b1;
        end else if (e && m_pos != FRAME - 1) begin
            bump_err();
            m_hunt = 1'b1;
            m_pos  = 0;
        end else begin
            model_pixel(m_pos, d, e);
        end
    endtask

    task automatic clear_stats();
        n_rr = 0; n_wr = 0; n_fd = 0; first_idx = -1;
        wr_min = 1024; wr_max = -1; rdy_low = 1'b0;
    endtask

    task automatic cycle(input logic v, input logic [29:0] d,
                         input logic s, input logic e, input logic r);
        @(negedge clk);
        valid = v; sink_data = d; sop = s; eop = e; row_release = r;
        #1;
        obs_ready = ready;
        if (!obs_ready) rdy_low = 1'b1;
        check("ready", 32'(obs_ready), 32'(!m_wait));
        last_acc = v && !m_wait;
        e_wr = 1'b0; e_rr = 1'b0; e_fd = 1'b0;
        if (r && m_held.size() > 0) begin
            m_held.delete(0);
            m_wait = 1'b0;
        end
        if (last_acc) model_beat(d, s, e);
        if (e_rr) rel_due.push_back(cyc + 3);
        @(posedge clk);
        #1;
        check("buf_write", 32'(buf_write), 32'(e_wr));
        if (e_wr) begin
            check("buf_address", 32'(buf_address), 32'(e_addr));
            check("buf_data", 32'(buf_data), 32'(e_data));
        end
        check("row_ready", 32'(row_ready), 32'(e_rr));
        if (e_rr) begin
            check("row_bank", 32'(row_bank), 32'(e_bank));
            check("row_index", 32'(row_index), 32'(e_idx));
        end
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("error_count", 32'(error_count), 32'(m_err));
        if (row_ready && n_rr == 0) first_idx = int'(row_index);
        n_rr += int'(row_ready);
        n_fd += int'(frame_done);
        if (buf_write) begin
            n_wr++;
            if (int'(buf_address) < wr_min) wr_min = int'(buf_address);
            if (int'(buf_address) > wr_max) wr_max = int'(buf_address);
        end
        cyc++;
    endtask

    task automatic beat(input logic r);
        cycle(1'b1, 30'($urandom), gpos == 0, gpos == FRAME - 1, r);
        if (last_acc) gpos = (gpos + 1) % FRAME;
    endtask

    // relmode: 0 no release, 1 release 2 cycles after row_ready, 2 random
    task automatic run(input int n, input int pv, input int relmode,
                       input logic glitch);
        logic v;
        logic r;
        logic s;
        logic e;
        for (int i = 0; i < n; i++) begin
            v = ($urandom_range(99) < pv);
            r = 1'b0;
            if (relmode == 1 && rel_due.size() > 0) begin
                if (rel_due[0] <= cyc) begin
                    r = 1'b1;
                    rel_due.delete(0);
                end
            end else if (relmode == 2) begin
                r = ($urandom_range(99) < 3);
            end
            s = (gpos == 0);
            e = (gpos == FRAME - 1);
            if (glitch && $urandom_range(1999) == 0) s = !s;
            if (glitch && $urandom_range(1999) == 0) e = !e;
            cycle(v, 30'($urandom), s, e, r);
            if (last_acc) gpos = (gpos + 1) % FRAME;
        end
    endtask

    // Reset lands mid-cycle so its effect is seen without a clock edge
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        valid = 1'b0; sop = 1'b0; eop = 1'b0; row_release = 1'b0;
        #1;
        check("rst_ready", 32'(ready), 32'(0));
        check("rst_buf_write", 32'(buf_write), 32'(0));
        check("rst_buf_address", 32'(buf_address), 32'(0));
        check("rst_buf_data", 32'(buf_data), 32'(0));
        check("rst_row_ready", 32'(row_ready), 32'(0));
        check("rst_row_bank", 32'(row_bank), 32'(0));
        check("rst_row_index", 32'(row_index), 32'(0));
        check("rst_frame_done", 32'(frame_done), 32'(0));
        check("rst_error_count", 32'(error_count), 32'(0));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        valid = 1'b0; sop = 1'b0; eop = 1'b0; row_release = 1'b0;
        sink_data = '0;
        clear_stats();
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].v, 30'($urandom), tbl[i].s, tbl[i].e, 1'b0);
            check("vec_ready", 32'(obs_ready), 32'(tbl[i].rdy));
            check("vec_write", 32'(buf_write), 32'(tbl[i].wr));
            check("vec_errors", 32'(error_count), 32'(tbl[i].err));
        end

        do_reset();
        clear_stats();
        run(FRAME, 100, 1, 1'b0);
        check("clean_rows", 32'(n_rr), 32'(ROWS));
        check("clean_writes", 32'(n_wr), 32'(ROWS * (CE - CS)));
        check("clean_frames", 32'(n_fd), 32'(1));
        check("clean_first_addr", 32'(wr_min), 32'(0));
        check("clean_errors", 32'(error_count), 32'(0));

        do_reset();
        run(2 * COLS, 100, 0, 1'b0);
        beat(1'b0);
        check("wait_ready", 32'(obs_ready), 32'(0));
        beat(1'b1);
        check("wait_rel_ready", 32'(obs_ready), 32'(0));
        clear_stats();
        beat(1'b0);
        check("resume_ready", 32'(obs_ready), 32'(1));
        run(COLS - 1, 100, 0, 1'b0);
        check("row2_writes", 32'(n_wr), 32'(CE - CS));
        check("row2_min_addr", 32'(wr_min), 32'h000);
        check("row2_max_addr", 32'(wr_max), 32'h1DF);
        check("row2_done", 32'(n_rr), 32'(1));

        do_reset();
        run(COLS, 100, 0, 1'b0);
        clear_stats();
        run(COLS - 1, 100, 0, 1'b0);
        beat(1'b1);
        run(20, 100, 0, 1'b0);
        check("same_cycle_ready_low", 32'(rdy_low), 32'(0));
        check("same_cycle_rows", 32'(n_rr), 32'(1));

        do_reset();
        run(5 * COLS + 100, 100, 1, 1'b0);
        clear_stats();
        cycle(1'b1, 30'($urandom), 1'b1, 1'b0, 1'b0);
        gpos = 1;
        run(COLS - 1, 100, 1, 1'b0);
        check("sop_err_count", 32'(error_count), 32'(1));
        check("sop_err_rows", 32'(n_rr), 32'(1));
        check("sop_err_index", 32'(first_idx), 32'(0));

        do_reset();
        run(10 * COLS, 100, 1, 1'b0);
        cycle(1'b1, 30'($urandom), 1'b0, 1'b1, 1'b0);
        check("eop_err_count", 32'(error_count), 32'(1));
        clear_stats();
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 30'($urandom), 1'b0, 1'b0, 1'b0);
        end
        check("hunt_writes", 32'(n_wr), 32'(0));
        gpos = 0;
        clear_stats();
        run(COLS, 100, 1, 1'b0);
        check("hunt_resume_rows", 32'(n_rr), 32'(1));
        check("hunt_resume_index", 32'(first_idx), 32'(0));
        check("hunt_resume_writes", 32'(n_wr), 32'(CE - CS));
        check("hunt_err_count", 32'(error_count), 32'(1));

        do_reset();
        run(3 * COLS + 200, 100, 1, 1'b0);
        do_reset();
        clear_stats();
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 30'($urandom), 1'b0, 1'b0, 1'b0);
        end
        check("post_reset_writes", 32'(n_wr), 32'(0));
        check("post_reset_rows", 32'(n_rr), 32'(0));

        do_reset();
        run(20000, 70, 2, 1'b1);

        do_reset();
        for (int i = 0; i < 260; i++) begin
            cycle(1'b1, 30'($urandom), 1'b1, 1'b0, 1'b0);
            cycle(1'b1, 30'($urandom), 1'b0, 1'b1, 1'b0);
        end
        check("err_saturate", 32'(error_count), 32'(255));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
